uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single management-FPGA UART transmitter (115200 baud link to the STM32) between several on-chip byte-stream sources. Packet-granular round-robin arbitration guarantees no interleaving of bytes from different sources on the wire. Sits between requester logic (management controller, sensor reporter, debug) and the UART `tx_data`/`tx_en`/`tx_done` ports, in the `clk_100mhz` domain.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 1000000: owner-stall limit in clocks. Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a byte on its `req_data` slice.
- `req_data`  in  8*NUM_REQ  byte i at bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte i is the final byte of its packet.
- `req_ready`  out  NUM_REQ  one-hot; byte i consumed this cycle.
- `grant`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `abort`  out  NUM_REQ  one-cycle pulse when an owner is evicted by timeout.
- `uart_tx_data`  out  8  byte to UART.
- `uart_tx_en`  out  1  one-cycle transmit strobe.
- `uart_tx_done`  in  1  one-cycle pulse from UART when the byte has finished.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, SEND, WAIT.
- **IDLE:** `grant`=0. If any `req_valid` is set:
  - Select the first set bit, searching from `(last_owner+1) mod NUM_REQ` upward with wrap.
  - Register `grant`. Go to SEND.
- **SEND:**
  - `req_ready[owner] = req_valid[owner]`, combinational and gated by state. All other `req_ready` bits are 0.
  - On accept: register `uart_tx_data`=byte, `uart_tx_en`=1 for one cycle, latch `req_last` into `last_flag`. Go to WAIT.
  - If the owner's `req_valid` is low: hold the grant (packet in progress) and stay in SEND.
- **WAIT:** on `uart_tx_done`:
  - `last_flag`=1: set `last_owner`=owner, clear `grant`, go to IDLE.
  - Otherwise return to SEND.
- `uart_tx_done` outside WAIT is ignored.
- Changes on `req_valid`/`req_data` of non-owners never affect the transfer in progress.
- The owner must hold `req_data` stable while `req_valid` is high and `req_ready` is low.
- A single-byte packet (`req_last` on the first byte) is legal.
- Reset values: state IDLE, `last_owner`=NUM_REQ-1 (requester 0 has first priority), `grant`=0, `req_ready`=0, `abort`=0, `uart_tx_data`=0, `uart_tx_en`=0, `busy`=0.
- Reset asserted mid-packet: state returns to IDLE immediately. The partial packet is abandoned with no abort pulse.

## Timing
- `req_valid` rises in IDLE at cycle 0:
  - `grant`/`busy` high at cycle 1.
  - `req_ready` high at cycle 1 (if valid).
  - `uart_tx_en` and data valid at cycle 2.
- `uart_tx_done` at cycle N: SEND at N+1. Next `req_ready` possible at N+1, next `uart_tx_en` at N+2.
- After the last byte's `uart_tx_done` at cycle N: IDLE at N+1, new `grant` at N+2. There is one dead cycle between packets.
- `uart_tx_en` is never high in two consecutive cycles. At most one byte is outstanding.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter runs in SEND while the owner's `req_valid` is low. It clears on accept and on entry to SEND.
  - When it reaches `TIMEOUT_CYCLES`: pulse `abort[owner]` for one cycle, set `last_owner`=owner, clear `grant`, go to IDLE.
- Macro undefined: no counter; `abort` is tied to 0; a stalled owner holds the UART indefinitely.

## Test plan
- **Single source:** req 0 sends the 3-byte packet 0x41,0x42,0x43 (`req_last` on 0x43), UART model returns done 10 cycles after each `tx_en`.
  - Required: exactly 3 `tx_en` pulses carrying 0x41/0x42/0x43 in order.
  - Required: `grant`=4'b0001 throughout; `busy` falls the cycle after the third done.
- **Round-robin:** req 0, 1 and 3 all valid from reset, each with a 2-byte packet.
  - Required: packets are emitted in order 0, 1, 3.
  - Then req 0 and 3 re-request: order 0, 3.
- **No interleave:** req 1 stalls `req_valid` for 50 cycles mid-packet while req 2 is valid.
  - Required: `grant` stays 4'b0010; no req 2 byte is sent until req 1's last byte is done.
- **Stray done:** pulse `uart_tx_done` in IDLE and in SEND.
  - Required: no state change and no `req_ready`.
- **Async reset:** assert `rst_n`=0 during WAIT of a 4-byte packet.
  - Required: all outputs are 0 immediately.
  - Required: after release, req 3 valid is granted first over nothing pending; with req 0 and 3 both valid, req 0 is granted.
- **With `UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20:** owner req 2 drops valid mid-packet.
  - Required: `abort`=4'b0100 for one cycle after 20 stalled cycles, then `grant` moves to a waiting req 3.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// Optional owner-stall eviction is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     abort,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_en,
  input  logic                   uart_tx_done,
  output logic                   busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic [IDX_W-1:0]   last_owner, last_owner_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [7:0]         tx_data_n;
  logic               tx_en_n;
  logic               last_flag, last_flag_n;

  logic [IDX_W-1:0]   pick, cand;
  logic               pick_found;
  logic               owner_valid;
  logic [7:0]         owner_byte;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   stall_cnt, stall_cnt_n;
  logic [NUM_REQ-1:0] abort_n;
  logic               stall_expired;
  assign stall_expired = (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  assign owner_valid = req_valid[owner];
  assign owner_byte  = req_data[{owner, 3'b000} +: 8];
  assign req_ready   = (state == SEND) ? (grant & req_valid) : '0;
  assign busy        = (state != IDLE);

  // Round-robin search starting just after the previous packet's owner.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_owner) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    grant_n      = grant;
    tx_data_n    = uart_tx_data;
    tx_en_n      = 1'b0;
    last_flag_n  = last_flag;
`ifdef UART_ARB_TIMEOUT_EN
    stall_cnt_n  = stall_cnt;
    abort_n      = '0;
`endif
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          owner_n = pick;
          grant_n = NUM_REQ'(1) << pick;
          state_n = SEND;
`ifdef UART_ARB_TIMEOUT_EN
          stall_cnt_n = '0;
`endif
        end
      end
      SEND: begin
        if (owner_valid) begin
          tx_data_n   = owner_byte;
          tx_en_n     = 1'b1;
          last_flag_n = req_last[owner];
          state_n     = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          stall_cnt_n = '0;
        end else if (stall_expired) begin
          abort_n      = grant;
          last_owner_n = owner;
          grant_n      = '0;
          state_n      = IDLE;
          stall_cnt_n  = '0;
        end else begin
          stall_cnt_n = stall_cnt + 1'b1;
`endif
        end
      end
      WAIT: begin
        if (uart_tx_done) begin
          if (last_flag) begin
            last_owner_n = owner;
            grant_n      = '0;
            state_n      = IDLE;
          end else begin
            state_n = SEND;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt_n = '0;
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= '0;
      last_owner   <= IDX_W'(NUM_REQ - 1);
      grant        <= '0;
      uart_tx_data <= '0;
      uart_tx_en   <= 1'b0;
      last_flag    <= 1'b0;
    end else begin
      state        <= state_n;
      owner        <= owner_n;
      last_owner   <= last_owner_n;
      grant        <= grant_n;
      uart_tx_data <= tx_data_n;
      uart_tx_en   <= tx_en_n;
      last_flag    <= last_flag_n;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      abort     <= '0;
    end else begin
      stall_cnt <= stall_cnt_n;
      abort     <= abort_n;
    end
  end
`else
  assign abort = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed sequences, a grant table and randomized
// packet rounds checked against a packet-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 20;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int STALL_LEN = 15;
`else
  localparam int STALL_LEN = 50;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready, grant, abort;
  logic [8*N-1:0] req_data;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_en, uart_tx_done, busy;
  logic           model_done, stray_done;

  assign uart_tx_done = model_done | stray_done;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .abort(abort),
    .uart_tx_data(uart_tx_data), .uart_tx_en(uart_tx_en),
    .uart_tx_done(uart_tx_done), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Per-requester byte streams: {last, byte}
  logic [8:0]  mem [N][1024];
  int unsigned head[N], tail[N], mhead[N];
  logic [N-1:0] force_stall, took;
  bit          rand_stall, lat_rand;
  int          lat, dcnt, m_last;
  int          got_q[$], exp_q[$];
  bit          outstanding, prev_en;

  function automatic bit queues_empty();
    bit e = 1;
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) e = 0;
    return e;
  endfunction

  function automatic int own_of(input logic [N-1:0] g);
    int r = 99;
    for (int i = 0; i < N; i++) if (g == (N'(1) << i)) r = i;
    return r;
  endfunction

  task automatic push_byte(input int r, input logic [7:0] b, input logic last);
    mem[r][tail[r]] = {last, b};
    tail[r]++;
  endtask

  task automatic push_pkt(input int r, input int len, input logic [7:0] base);
    for (int j = 0; j < len; j++) push_byte(r, base + 8'(j), j == len - 1);
  endtask

  // Requester drivers: pop on a handshake seen before the edge, then present the next byte.
  initial begin
    req_valid = '0; req_data = '0; req_last = '0; took = '0;
    forever begin
      @(negedge clk);
      took = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (took[i]) head[i]++;
        if (head[i] != tail[i] && !force_stall[i] &&
            !(rand_stall && grant[i] && ($urandom_range(3) == 0))) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = mem[i][head[i]][7:0];
          req_last[i]         = mem[i][head[i]][8];
        end else begin
          req_valid[i]        = 1'b0;
          req_data[8*i +: 8]  = 8'($urandom);
          req_last[i]         = 1'($urandom);
        end
      end
    end
  end

  // UART model: done pulse a set number of cycles after each transmit strobe.
  initial begin
    model_done = 1'b0;
    dcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      model_done = 1'b0;
      if (!rst_n) dcnt = 0;
      else begin
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) model_done = 1'b1;
        end
        if (uart_tx_en) dcnt = lat_rand ? int'($urandom_range(6, 1)) : lat;
      end
    end
  end

  // Wire monitor: records {owner, byte} and checks strobe spacing / single outstanding byte.
  initial begin
    outstanding = 0;
    prev_en = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 0;
        prev_en = 0;
      end else begin
        if (uart_tx_done) outstanding = 0;
        if (uart_tx_en) begin
          check("en_back_to_back", 32'(prev_en), 0);
          check("en_while_outstanding", 32'(outstanding), 0);
          got_q.push_back(own_of(grant) * 256 + int'(uart_tx_data));
          outstanding = 1;
        end
        prev_en = uart_tx_en;
      end
    end
  end

  // Reference: whole packets, next owner = first pending requester after the previous owner.
  task automatic model_round();
    int unsigned p[N];
    bit found, lb;
    int idx;
    for (int i = 0; i < N; i++) p[i] = mhead[i];
    do begin
      found = 0;
      for (int k = 1; k <= N && !found; k++) begin
        idx = (m_last + k) % N;
        if (p[idx] != tail[idx]) begin
          found = 1;
          do begin
            lb = mem[idx][p[idx]][8];
            exp_q.push_back(idx * 256 + int'(mem[idx][p[idx]][7:0]));
            p[idx]++;
          end while (!lb && p[idx] != tail[idx]);
          m_last = idx;
        end
      end
    end while (found);
  endtask

  task automatic compare_q(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s_byte%0d", name, k), 32'(got_q[k]), 32'(exp_q[k]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0, quiet = 0;
    while (quiet < 3 && n < 5000) begin
      @(negedge clk);
      n++;
      if (!busy && !outstanding && queues_empty()) quiet++; else quiet = 0;
    end
    if (quiet < 3) timeout_fail(name);
  endtask

  task automatic wait_en(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!uart_tx_en && n < 500);
    if (!uart_tx_en) timeout_fail(name);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!uart_tx_done && n < 500);
    if (!uart_tx_done) timeout_fail(name);
  endtask

  task automatic wait_any_valid(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (req_valid == '0 && n < 50);
    if (req_valid == '0) timeout_fail(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    force_stall = '0;
    for (int i = 0; i < N; i++) tail[i] = head[i];
    repeat (2) @(negedge clk);
    got_q.delete();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int           prev;
    logic [N-1:0] pat;
    logic [N-1:0] exp_grant;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int nd;
    vecs[0] = '{0, 4'b1010, 4'b0010};
    vecs[1] = '{1, 4'b1010, 4'b1000};
    vecs[2] = '{3, 4'b1010, 4'b0010};
    vecs[3] = '{2, 4'b0101, 4'b0001};
    vecs[4] = '{0, 4'b0001, 4'b0001};
    vecs[5] = '{3, 4'b1111, 4'b0001};
    vecs[6] = '{1, 4'b0111, 4'b0100};
    vecs[7] = '{2, 4'b1100, 4'b1000};

    rst_n = 1'b0; stray_done = 1'b0; force_stall = '0;
    rand_stall = 0; lat_rand = 0; lat = 10;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    repeat (3) @(negedge clk);

    check("rst_grant", 32'(grant), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_abort", 32'(abort), 0);
    check("rst_data", 32'(uart_tx_data), 0);
    check("rst_en", 32'(uart_tx_en), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // Single source, cycle-accurate first byte
    push_byte(0, 8'h41, 0); push_byte(0, 8'h42, 0); push_byte(0, 8'h43, 1);
    wait_any_valid("t1_valid");
    check("t1_c0_grant", 32'(grant), 0);
    @(negedge clk);
    check("t1_c1_grant", 32'(grant), 32'h1);
    check("t1_c1_busy", 32'(busy), 1);
    check("t1_c1_ready", 32'(req_ready), 32'h1);
    check("t1_c1_en", 32'(uart_tx_en), 0);
    @(negedge clk);
    check("t1_c2_en", 32'(uart_tx_en), 1);
    check("t1_c2_data", 32'(uart_tx_data), 32'h41);
    nd = 0;
    for (int n = 0; n < 300 && nd < 3; n++) begin
      @(negedge clk);
      check("t1_grant_hold", 32'(grant), 32'h1);
      if (uart_tx_done) nd++;
    end
    if (nd < 3) timeout_fail("t1_done");
    check("t1_busy_at_last_done", 32'(busy), 1);
    @(negedge clk);
    check("t1_busy_after_last_done", 32'(busy), 0);
    check("t1_grant_after", 32'(grant), 0);
    wait_idle("t1_idle");
    exp_q = '{32'h041, 32'h042, 32'h043};
    compare_q("t1");

    // Round-robin from reset: 0,1,3 then 0,3
    @(negedge clk);
    rst_n = 1'b0;
    push_pkt(0, 2, 8'h10); push_pkt(1, 2, 8'h20); push_pkt(3, 2, 8'h30);
    repeat (2) @(negedge clk);
    got_q.delete();
    rst_n = 1'b1;
    wait_idle("t2a_idle");
    exp_q = '{32'h010, 32'h011, 32'h120, 32'h121, 32'h330, 32'h331};
    compare_q("t2a");
    push_pkt(3, 2, 8'h38); push_pkt(0, 2, 8'h18);
    wait_idle("t2b_idle");
    exp_q = '{32'h018, 32'h019, 32'h338, 32'h339};
    compare_q("t2b");

    // No interleave while the owner stalls mid-packet
    push_pkt(1, 3, 8'hA0); push_pkt(2, 2, 8'hB0);
    wait_en("t3_first_en");
    check("t3_owner", 32'(grant), 32'h2);
    force_stall[1] = 1'b1;
    for (int n = 0; n < STALL_LEN; n++) begin
      @(negedge clk);
      check("t3_grant_hold", 32'(grant), 32'h2);
      if (n > 12) check("t3_no_en", 32'(uart_tx_en), 0);
    end
`ifndef UART_ARB_TIMEOUT_EN
    check("t3_no_abort", 32'(abort), 0);
`endif
    force_stall[1] = 1'b0;
    wait_idle("t3_idle");
    exp_q = '{32'h1A0, 32'h1A1, 32'h1A2, 32'h2B0, 32'h2B1};
    compare_q("t3");

    // Stray done in IDLE and in SEND
    @(negedge clk); stray_done = 1'b1;
    @(negedge clk); stray_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t4_idle_busy", 32'(busy), 0);
      check("t4_idle_ready", 32'(req_ready), 0);
      check("t4_idle_en", 32'(uart_tx_en), 0);
    end
    lat = 4;
    push_pkt(0, 2, 8'hC0);
    wait_en("t4_first_en");
    force_stall[0] = 1'b1;
    wait_done("t4_done");
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t4_send_busy", 32'(busy), 1);
      check("t4_send_grant", 32'(grant), 32'h1);
      check("t4_send_ready", 32'(req_ready), 0);
      check("t4_send_en", 32'(uart_tx_en), 0);
    end
    force_stall[0] = 1'b0;
    wait_idle("t4_idle");
    exp_q = '{32'h0C0, 32'h0C1};
    compare_q("t4");

    // Asynchronous reset during WAIT
    lat = 10;
    push_pkt(2, 4, 8'hD0);
    wait_en("t5_en1");
    wait_en("t5_en2");
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_grant", 32'(grant), 0);
    check("t5_ready", 32'(req_ready), 0);
    check("t5_abort", 32'(abort), 0);
    check("t5_data", 32'(uart_tx_data), 0);
    check("t5_en", 32'(uart_tx_en), 0);
    check("t5_busy", 32'(busy), 0);
    for (int i = 0; i < N; i++) tail[i] = head[i];
    repeat (2) @(negedge clk);
    got_q.delete();
    rst_n = 1'b1;
    push_byte(3, 8'hE3, 1);
    wait_any_valid("t5_v3");
    @(negedge clk);
    check("t5_grant3", 32'(grant), 32'h8);
    wait_idle("t5_idle3");
    exp_q = '{32'h3E3};
    compare_q("t5a");
    do_reset();
    push_byte(3, 8'hF3, 1); push_byte(0, 8'hF0, 1);
    wait_any_valid("t5_v03");
    @(negedge clk);
    check("t5_grant0", 32'(grant), 32'h1);
    wait_idle("t5_idle03");
    exp_q = '{32'h0F0, 32'h3F3};
    compare_q("t5b");

    // Grant table: previous owner + pending pattern -> next grant
    lat = 2;
    for (int v = 0; v < 8; v++) begin
      push_byte(vecs[v].prev, 8'h60 + 8'(v), 1);
      wait_idle("tab_prev");
      got_q.delete();
      for (int r = 0; r < N; r++) if (vecs[v].pat[r]) push_byte(r, 8'h70 + 8'(r), 1);
      wait_any_valid("tab_valid");
      @(negedge clk);
      check($sformatf("tab%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
      wait_idle("tab_drain");
      got_q.delete();
    end

    // Randomized rounds against the packet-level model
    do_reset();
    m_last = N - 1;
    rand_stall = 1;
    lat_rand = 1;
    for (int rnd = 0; rnd < 8; rnd++) begin
      for (int i = 0; i < N; i++) mhead[i] = head[i];
      for (int r = 0; r < N; r++) begin
        int npk = int'($urandom_range(2, 0));
        for (int p = 0; p < npk; p++) begin
          int len = int'($urandom_range(4, 1));
          for (int j = 0; j < len; j++) push_byte(r, 8'($urandom), j == len - 1);
        end
      end
      model_round();
      wait_idle("rnd_idle");
      compare_q($sformatf("rnd%0d", rnd));
    end
    rand_stall = 0;
    lat_rand = 0;

`ifdef UART_ARB_TIMEOUT_EN
    // Owner eviction after TO stalled cycles
    do_reset();
    lat = 5;
    push_pkt(2, 3, 8'h90); push_byte(3, 8'h93, 1);
    wait_en("t8_en");
    force_stall[2] = 1'b1;
    wait_done("t8_done");
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      if (k == TO) check("t8_abort_early", 32'(abort), 0);
      if (k == TO + 1) check("t8_abort", 32'(abort), 32'h4);
    end
    @(negedge clk);
    check("t8_abort_pulse", 32'(abort), 0);
    check("t8_grant3", 32'(grant), 32'h8);
    tail[2] = head[2];
    force_stall[2] = 1'b0;
    wait_idle("t8_idle");
    exp_q = '{32'h290, 32'h393};
    compare_q("t8");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
